// File: rtl/seq_detector_param.sv
// Serial pattern detector with a run-time loadable SEQ_LEN-bit pattern and overlap select.
// Optional saturating match counter under macro SEQ_DETECTOR_MATCH_COUNT_EN.
module seq_detector_param #(
   parameter int unsigned        SEQ_LEN         = 4,
   parameter int unsigned        CNT_W           = 8,
   parameter logic [SEQ_LEN-1:0] DEFAULT_PATTERN = SEQ_LEN'(4'b1101)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               A,
   input  logic               en,
   input  logic               overlap,
   input  logic               load_pat,
   input  logic [SEQ_LEN-1:0] pattern,
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
   input  logic               clr_cnt,
   output logic [CNT_W-1:0]   match_count,
`endif
   output logic               Z
);

   localparam int unsigned     FW       = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;
   localparam logic [FW-1:0]   FILL_MAX = FW'(SEQ_LEN - 1);

   if (SEQ_LEN < 2 || SEQ_LEN > 16 || CNT_W < 1) begin : g_bad_cfg
      $error("seq_detector_param: SEQ_LEN must be 2..16 and CNT_W >= 1");
   end

   // The fill counter is the state of the F0..F(SEQ_LEN-1) machine; the action
   // enum decodes what this cycle does to it.
   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_LOAD,
      ACT_SHIFT,
      ACT_MATCH
   } act_t;

   act_t               act;
   logic [SEQ_LEN-1:0] pat_reg, pat_nxt;
   logic [SEQ_LEN-2:0] hist, hist_nxt;
   logic [FW-1:0]      fill, fill_nxt;
   logic               z_nxt;
   logic [SEQ_LEN-1:0] cand;

   assign cand = {hist, A};

   always_comb begin
      act      = ACT_HOLD;
      pat_nxt  = pat_reg;
      hist_nxt = hist;
      fill_nxt = fill;
      z_nxt    = 1'b0;
      if (load_pat)
         act = ACT_LOAD;
      else if (en)
         act = (fill == FILL_MAX && cand == pat_reg) ? ACT_MATCH : ACT_SHIFT;

      case (act)
         ACT_LOAD: begin
            pat_nxt  = pattern;
            hist_nxt = '0;
            fill_nxt = '0;
         end
         ACT_SHIFT: begin
            hist_nxt = cand[SEQ_LEN-2:0];
            fill_nxt = (fill == FILL_MAX) ? fill : fill + 1'b1;
         end
         ACT_MATCH: begin
            z_nxt = 1'b1;
            if (overlap) begin
               hist_nxt = cand[SEQ_LEN-2:0];
            end else begin
               hist_nxt = '0;
               fill_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_reg <= DEFAULT_PATTERN;
         hist    <= '0;
         fill    <= '0;
         Z       <= 1'b0;
      end else begin
         pat_reg <= pat_nxt;
         hist    <= hist_nxt;
         fill    <= fill_nxt;
         Z       <= z_nxt;
      end
   end

`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = match_count;
      if (clr_cnt)
         cnt_nxt = '0;
      else if (act == ACT_MATCH && match_count != '1)
         cnt_nxt = match_count + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         match_count <= '0;
      else
         match_count <= cnt_nxt;
   end
`endif

endmodule
